spi_master_serdes: RTL and testbench
====================================

// Module: spi_master_serdes
// PURPOSE
//  System-clock SPI master serializer: generates ss_n/sclk/mosi from parallel words, samples miso.
//  Sits between the bus-side register/FIFO logic (tx/rx streams) and the SPI pins.
//  Supports all four CPOL/CPHA modes and back-to-back words under one ss_n assertion.
// PARAMETERS
//  DW    8     data word width in bits, MSB first
//  DIVW  8     width of clock-divider config
//  CPOL  1'b0  sclk idle level
//  CPHA  1'b0  0: sample on leading edge; 1: sample on trailing edge
// PORTS
//  clk       in   1     system clock
//  rst       in   1     synchronous reset, active high
//  cfg_div   in   DIVW  half-period H = cfg_div+1 clk cycles; captured at word accept
//  tx_valid  in   1     tx word valid
//  tx_ready  out  1     tx word accepted when tx_valid & tx_ready
//  tx_data   in   DW    word to transmit
//  tx_last   in   1     release ss_n after this word
//  rx_valid  out  1     one-cycle pulse, rx_data valid (no backpressure)
//  rx_data   out  DW    received word, held until next rx_valid
//  busy      out  1     ss_n asserted or transfer in progress
//  ss_n      out  1     slave select, active low
//  sclk      out  1     serial clock
//  mosi      out  1     serial data out
//  miso      in   1     serial data in, sampled on clk at the sample edge
// BEHAVIOUR
//  Reset: ss_n=1, sclk=CPOL, mosi=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, state IDLE.
//  Reset mid-transfer: same values next cycle; partial word discarded, no rx_valid.
//  States: IDLE -> SETUP -> SHIFT -> (SHIFT | WAIT | HOLD); WAIT -> SHIFT; HOLD -> IDLE.
//  IDLE: tx_ready=1; accept at cycle t -> ss_n=0 from t+1, load shifter, capture H, go SETUP.
//  SETUP: H cycles; CPHA=0 mosi=tx_data[DW-1] from t+1; CPHA=1 mosi unchanged until edge 1.
//  SHIFT: 2*DW sclk toggles, edge k at cycle t+1+k*H (odd k leading, even k trailing).
//   CPHA=0: sample miso on leading, shift mosi on trailing (except final edge).
//   CPHA=1: shift mosi on leading, sample miso on trailing.
//  End of word (edge 2*DW at cycle e): rx_valid=1 at e+1 with all DW sampled bits, MSB first.
//  tx_ready=1 during cycle e when current word had tx_last=0.
//   Accept at e: next word edge 1 at e+H, ss_n stays low, no SETUP.
//   No accept at e and tx_last=0: WAIT, sclk=CPOL, ss_n=0, tx_ready=1;
//    accept at w -> edge 1 at w+H.
//   tx_last=1: HOLD for H cycles, ss_n=1 at e+H, IDLE (tx_ready=1) at e+H.
//  tx_ready=0 in SETUP, HOLD and SHIFT except cycle e.
//  cfg_div changes outside accept cycles are ignored; cfg_div=0 gives sclk = clk/2.
//  Divider counter wraps from 0 to H-1 on every edge; no drift across back-to-back words.
//  busy = ~ss_n | (state != IDLE).
// STRUCTURE
//  Package spi_pkg: state enum (IDLE, SETUP, SHIFT, WAIT, HOLD), mode constants for CPOL/CPHA.
//  Sub-module spi_clk_div: loadable half-period down-counter with edge strobe; one instance.
//  Top: FSM, DW-bit tx/rx shift registers, edge counter of width $clog2(2*DW)+1.
// TESTING
//  Mode0, DW=8, div=0, tx 0xA5 last, miso=mosi loopback -> rx_data=0xA5; rx_valid at t+18;
//   ss_n low t+1..t+17.
//  All 4 CPOL/CPHA, div=3: tx 0x3C -> sclk idles at CPOL, 4-cycle half-period, rx=0x3C.
//  Back-to-back 0x01,0x80 (first tx_last=0) accepted at boundary -> ss_n never high;
//   two rx_valid pulses 16 cycles apart at div=0.
//  tx_last=0 then tx_valid low 10 cycles -> WAIT: ss_n=0, sclk=CPOL steady; next word resumes.
//  rst at edge 7 of a word -> next cycle ss_n=1, sclk=CPOL, no rx_valid; new word completes normally.
//  miso tied 1, tx 0x00 -> rx_data=0xFF; cfg_div changed mid-word -> half-period unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master serializer: FSM state encoding and
// symbolic names for the CPOL/CPHA mode parameters.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD
    } spi_state_e;

    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;
    localparam logic CPHA_LEADING   = 1'b0;
    localparam logic CPHA_TRAILING  = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period down-counter: strobe fires on the cycle the count reaches zero,
// after which the count wraps to reload_val so successive edges stay H apart.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    input  logic            run,
    input  logic [DIVW-1:0] reload_val,
    output logic            strobe
);

    logic [DIVW-1:0] cnt;

    assign strobe = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run) begin
            cnt <= strobe ? reload_val : cnt - DIVW'(1);
        end
    end

endmodule

// File: rtl/spi_master_serdes.sv
// SPI master serializer: turns accepted tx words into ss_n/sclk/mosi activity,
// samples miso into rx words, and chains words under one ss_n assertion.
module spi_master_serdes
    import spi_pkg::*;
#(
    parameter int   DW   = 8,
    parameter int   DIVW = 8,
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIVW-1:0] cfg_div,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [DW-1:0]   tx_data,
    input  logic            tx_last,
    output logic            rx_valid,
    output logic [DW-1:0]   rx_data,
    output logic            busy,
    output logic            ss_n,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso
);

    localparam int            EW        = $clog2(2 * DW) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW);

    spi_state_e      state, state_nx;
    logic [DIVW-1:0] h_m1;
    logic            last_q;
    logic [EW-1:0]   ecnt;
    logic [DW-1:0]   tx_sh, rx_sh;

    logic            accept, end_cyc, resume, sck_edge, leading;
    logic            shift_out, sample_in;
    logic            div_load, div_run, div_strobe;
    logic [DIVW-1:0] div_load_val;

    spi_clk_div #(.DIVW(DIVW)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .load_val   (div_load_val),
        .run        (div_run),
        .reload_val (h_m1),
        .strobe     (div_strobe)
    );

    assign busy = ~ss_n | (state != IDLE);

    // End cycle e is the cycle right after the final edge; a follow-on word
    // accepted there (or in WAIT) gets its first edge H cycles later, which
    // for H=1 means the edge coincides with the accept itself.
    always_comb begin
        end_cyc      = (state == SHIFT) && (ecnt == LAST_EDGE);
        tx_ready     = (state == IDLE) || (state == WAIT) || (end_cyc && !last_q);
        accept       = tx_valid && tx_ready;
        resume       = accept && (state != IDLE);
        div_run      = (state == SETUP) || (state == HOLD) || ((state == SHIFT) && !end_cyc);
        sck_edge     = (div_strobe && (state == SETUP || (state == SHIFT && !end_cyc)))
                     || (resume && (cfg_div == '0));
        leading      = resume || !ecnt[0];
        shift_out    = sck_edge && ((CPHA == CPHA_TRAILING) ? leading
                                    : (!leading && (ecnt != LAST_EDGE - EW'(1))));
        sample_in    = sck_edge && ((CPHA == CPHA_TRAILING) ? !leading : leading);
        div_load     = 1'b0;
        div_load_val = cfg_div;
        if (accept && state == IDLE) begin
            div_load = 1'b1;
        end else if (resume) begin
            div_load     = 1'b1;
            div_load_val = (cfg_div == '0) ? '0 : cfg_div - DIVW'(1);
        end else if (end_cyc && last_q) begin
            div_load     = 1'b1;
            div_load_val = h_m1 - DIVW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = SETUP;
            SETUP: if (sck_edge) state_nx = SHIFT;
            SHIFT: begin
                if (end_cyc) begin
                    if (accept)           state_nx = SHIFT;
                    else if (!last_q)     state_nx = WAIT;
                    else if (h_m1 == '0)  state_nx = IDLE;
                    else                  state_nx = HOLD;
                end
            end
            WAIT:  if (accept) state_nx = SHIFT;
            HOLD:  if (div_strobe) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ss_n     <= 1'b1;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            ecnt     <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            h_m1     <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            ss_n     <= (state_nx == IDLE);
            rx_valid <= end_cyc;
            if (end_cyc) rx_data <= rx_sh;
            if (accept) begin
                h_m1   <= cfg_div;
                last_q <= tx_last;
            end
            if (sck_edge) sclk <= ~sclk;

            if (accept)        ecnt <= (resume && cfg_div == '0) ? EW'(1) : '0;
            else if (sck_edge) ecnt <= ecnt + EW'(1);

            // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for a leading edge.
            if (accept) begin
                if (CPHA == CPHA_LEADING || sck_edge) begin
                    mosi  <= tx_data[DW-1];
                    tx_sh <= {tx_data[DW-2:0], 1'b0};
                end else begin
                    tx_sh <= tx_data;
                end
            end else if (shift_out) begin
                mosi  <= tx_sh[DW-1];
                tx_sh <= {tx_sh[DW-2:0], 1'b0};
            end

            if (sample_in) rx_sh <= {rx_sh[DW-2:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master_serdes.sv
// Runs all four CPOL/CPHA variants in lockstep against a timeline model of
// the SPI frame (interval fills per word) plus hand-computed spot checks.
module tb_spi_master_serdes;

    localparam int DW   = 8;
    localparam int DIVW = 8;
    localparam int NM   = 4;
    localparam int MAXC = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DIVW-1:0] cfg_div = '0;
    logic tx_valid = 1'b0;
    logic tx_last  = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic miso_one = 1'b0;

    logic [NM-1:0] tx_ready, rx_valid, busy, ss_n, sclk, mosi, miso;
    logic [NM-1:0][DW-1:0] rx_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar m = 0; m < NM; m++) begin : g_mode
        localparam logic CPOL_M = (m >= 2);
        localparam logic CPHA_M = (m % 2 == 1);
        assign miso[m] = miso_one ? 1'b1 : mosi[m];
        spi_master_serdes #(.DW(DW), .DIVW(DIVW), .CPOL(CPOL_M), .CPHA(CPHA_M)) u_dut (
            .clk(clk), .rst(rst), .cfg_div(cfg_div),
            .tx_valid(tx_valid), .tx_ready(tx_ready[m]), .tx_data(tx_data), .tx_last(tx_last),
            .rx_valid(rx_valid[m]), .rx_data(rx_data[m]), .busy(busy[m]),
            .ss_n(ss_n[m]), .sclk(sclk[m]), .mosi(mosi[m]), .miso(miso[m])
        );
    end

    // Expected per-cycle timeline; e_act marks sclk away from its idle level.
    bit          e_ssn [MAXC];
    bit          e_act [MAXC];
    bit          e_rdy [MAXC];
    bit          e_rxv [MAXC];
    logic [DW-1:0] e_rxd [MAXC];

    task automatic model_reset(input int r);
        for (int c = r + 1; c < MAXC; c++) begin
            e_ssn[c] = 1; e_act[c] = 0; e_rdy[c] = 1; e_rxv[c] = 0; e_rxd[c] = '0;
        end
    endtask

    task automatic model_word(input int t, input logic [DW-1:0] d, input bit last, input int h);
        int c1, e;
        c1 = e_ssn[t] ? t + 1 + h : t + h;
        e  = c1 + (2 * DW - 1) * h;
        for (int c = t + 1; c < MAXC; c++) e_ssn[c] = 0;
        for (int c = t + 1; c < e && c < MAXC; c++) e_rdy[c] = 0;
        for (int k = 0; k < DW; k++)
            for (int c = c1 + 2 * k * h; c < c1 + (2 * k + 1) * h && c < MAXC; c++) e_act[c] = 1;
        if (last) begin
            for (int c = e; c < e + h && c < MAXC; c++) e_rdy[c] = 0;
            for (int c = e + h; c < MAXC; c++) begin e_ssn[c] = 1; e_rdy[c] = 1; end
        end else if (e < MAXC) begin
            e_rdy[e] = 1;
        end
        if (e + 1 < MAXC) e_rxv[e + 1] = 1;
        for (int c = e + 1; c < MAXC; c++) e_rxd[c] = miso_one ? '1 : d;
    endtask

    // Spot checks are queued here and counted by the compare process.
    string lit_nm [128];
    int    lit_act[128];
    int    lit_exp[128];
    int    lit_n = 0;
    int    lit_done = 0;
    int    vecs = 0;
    int    errs = 0;

    task automatic lit(input string nm, input int a, input int x);
        if (lit_n < 128) begin
            lit_nm[lit_n] = nm; lit_act[lit_n] = a; lit_exp[lit_n] = x; lit_n++;
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            for (int m = 0; m < NM; m++) begin
                logic [DW+4:0] a, x;
                a = {ss_n[m], sclk[m], tx_ready[m], busy[m], rx_valid[m], rx_data[m]};
                x = {e_ssn[cyc], e_act[cyc] ^ (m >= 2), e_rdy[cyc], !e_ssn[cyc], e_rxv[cyc], e_rxd[cyc]};
                vecs++;
                if (a !== x) begin
                    errs++;
                    $display("FAIL pins cyc %0d mode %0d: got %b want %b (ss_n,sclk,rdy,busy,rxv,rxd)",
                             cyc, m, a, x);
                end
            end
        end
        while (lit_done < lit_n) begin
            vecs++;
            if (lit_act[lit_done] != lit_exp[lit_done]) begin
                errs++;
                $display("FAIL %s: got 'h%0h want 'h%0h", lit_nm[lit_done],
                         lit_act[lit_done], lit_exp[lit_done]);
            end
            lit_done++;
        end
    end

    // Observations on mode 0 for the hand-computed checks.
    int   obs_c[$];
    int   obs_d[$];
    int   tog[$];
    int   ssn_low = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rx_valid[0]) begin obs_c.push_back(cyc); obs_d.push_back(int'(rx_data[0])); end
            if (!ss_n[0]) ssn_low++;
            if (sclk[0] !== prev_sclk) tog.push_back(cyc);
            prev_sclk = sclk[0];
        end
    end

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last, input int div, output int t);
        int n;
        n = 0; t = -1;
        tx_valid = 1'b1; tx_data = d; tx_last = last; cfg_div = DIVW'(div);
        while (n < 400 && t < 0) begin
            if (e_rdy[cyc]) begin
                t = cyc;
                model_word(cyc, d, last, div + 1);
            end else begin
                @(posedge clk); #1; n++;
            end
        end
        if (t < 0) lit("accept_timeout", 0, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic check_rx_all(input string nm, input int x);
        for (int m = 0; m < NM; m++) lit(nm, int'(rx_data[m]), x);
    endtask

    initial begin
        int ta, tb, e, bo, bl, bt;
        model_reset(-1);
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            lit("reset_ss_n", int'(ss_n[m]), 1);
            lit("reset_sclk", int'(sclk[m]), (m >= 2) ? 1 : 0);
            lit("reset_mosi", int'(mosi[m]), 0);
            lit("reset_tx_ready", int'(tx_ready[m]), 1);
            lit("reset_busy", int'(busy[m]), 0);
        end
        rst = 1'b0;
        wait_until(5);

        // Single word, fastest divider, loopback.
        bo = obs_c.size(); bl = ssn_low;
        send_word(8'hA5, 1'b1, 0, ta);
        wait_until(ta + 25);
        lit("t1_rxv_cycle", qat(obs_c, bo), ta + 18);
        lit("t1_rx_data", qat(obs_d, bo), 'hA5);
        lit("t1_ssn_low_cycles", ssn_low - bl, 17);
        check_rx_all("t1_rx_all", 'hA5);

        // Divider 3: four-cycle half period in every mode.
        bt = tog.size();
        send_word(8'h3C, 1'b1, 3, ta);
        wait_until(ta + 80);
        lit("t2_first_edge", qat(tog, bt), ta + 5);
        lit("t2_half_period", qat(tog, bt + 1) - qat(tog, bt), 4);
        lit("t2_edge_count", tog.size() - bt, 16);
        check_rx_all("t2_rx_all", 'h3C);

        // Back-to-back words at the word boundary.
        bo = obs_c.size(); bl = ssn_low;
        send_word(8'h01, 1'b0, 0, ta);
        send_word(8'h80, 1'b1, 0, tb);
        lit("t3_accept_at_boundary", tb, ta + 17);
        wait_until(tb + 25);
        lit("t3_rxv_spacing", qat(obs_c, bo + 1) - qat(obs_c, bo), 16);
        lit("t3_rx_first", qat(obs_d, bo), 'h01);
        lit("t3_rx_second", qat(obs_d, bo + 1), 'h80);
        lit("t3_ssn_low_cycles", ssn_low - bl, 33);

        // Gap between words parks in WAIT.
        send_word(8'h5A, 1'b0, 1, ta);
        e = ta + 33;
        wait_until(e + 1);
        bt = tog.size();
        wait_until(e + 11);
        lit("t4_wait_toggles", tog.size() - bt, 0);
        lit("t4_wait_ss_n", int'(ss_n[0]), 0);
        send_word(8'hC3, 1'b1, 1, tb);
        lit("t4_resume_accept", tb, e + 11);
        wait_until(tb + 45);
        check_rx_all("t4_rx_all", 'hC3);

        // Reset while edge 7 is on the pins.
        bo = obs_c.size();
        send_word(8'h96, 1'b1, 0, ta);
        wait_until(ta + 8);
        rst = 1'b1;
        model_reset(cyc);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int m = 0; m < NM; m++) begin
            lit("t5_rst_ss_n", int'(ss_n[m]), 1);
            lit("t5_rst_sclk", int'(sclk[m]), (m >= 2) ? 1 : 0);
        end
        wait_until(ta + 25);
        lit("t5_no_rxv", obs_c.size() - bo, 0);
        send_word(8'h69, 1'b1, 0, tb);
        wait_until(tb + 25);
        check_rx_all("t5_rx_after_reset", 'h69);

        // miso stuck high; divider changed after accept must not take effect.
        miso_one = 1'b1;
        bt = tog.size();
        send_word(8'h00, 1'b1, 2, ta);
        cfg_div = 8'd7;
        wait_until(ta + 60);
        lit("t6_half_period_late", qat(tog, bt + 11) - qat(tog, bt + 10), 3);
        check_rx_all("t6_rx_ones", 'hFF);
        miso_one = 1'b0;

        wait_until(cyc + 3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
